// File: rtl/fle_frac_param.sv
// Fracturable K-input logic element with a serial configuration chain.
// It can act as one K-LUT or as two (K-1)-LUTs, and each output can be taken combinationally or from a flip-flop.
module fle_frac_param #(
    parameter int K    = 6,
    parameter int FRAC = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfg_done,
    input  logic         ccff_shift,
    input  logic         ccff_head,
    input  logic [K-1:0] fle_in,
    input  logic         fle_en,
    output logic [1:0]   fle_out,
    output logic         ccff_tail,
    output logic         cfg_full
);

    localparam int LUT_N = 1 << K;
    localparam int CFG_W = LUT_N + 3;
    localparam int CNT_W = $clog2(CFG_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_W);

    logic [CFG_W-1:0] cfg;
    logic [CNT_W-1:0] cfg_cnt;
    logic [LUT_N-1:0] lut;
    logic             frac_mode;
    logic [1:0]       reg_sel;
    logic [K-2:0]     sub_idx;
    logic [1:0]       lut_o;
    logic [1:0]       ff;

    assign lut       = cfg[LUT_N-1:0];
    assign frac_mode = (FRAC != 0) && cfg[LUT_N];
    assign reg_sel   = cfg[LUT_N+2:LUT_N+1];
    assign sub_idx   = fle_in[K-2:0];
    assign ccff_tail = cfg[CFG_W-1];
    assign cfg_full  = (cfg_cnt == CNT_MAX);

    // A user reset while locked must not destroy the loaded function.
    always_ff @(posedge clk) begin
        if (reset && !cfg_done) begin
            cfg     <= '0;
            cfg_cnt <= '0;
        end else if (ccff_shift && !cfg_done) begin
            cfg <= {cfg[CFG_W-2:0], ccff_head};
            if (cfg_cnt != CNT_MAX)
                cfg_cnt <= cfg_cnt + 1'b1;
        end
    end

    always_comb begin
        lut_o = '0;
        if (frac_mode) begin
            lut_o[0] = lut[{1'b0, sub_idx}];
            lut_o[1] = lut[{1'b1, sub_idx}];
        end else begin
            lut_o[0] = lut[fle_in];
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            ff <= '0;
        else if (fle_en)
            ff <= lut_o;
    end

    // Outputs stay quiet until the chain is locked.
    always_comb begin
        fle_out = '0;
        if (cfg_done) begin
            for (int i = 0; i < 2; i++)
                fle_out[i] = reg_sel[i] ? ff[i] : lut_o[i];
        end
    end

endmodule

// File: tb/tb_fle_frac_param.sv
// Self-checking bench for fle_frac_param (K=6) using a queue-based model of the config chain.
module tb_fle_frac_param;

    localparam int K = 6;
    localparam int N = 64;
    localparam int W = 67;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cfg_done = 1'b0;
    logic         ccff_shift = 1'b0;
    logic         ccff_head = 1'b0;
    logic [K-1:0] fle_in = '0;
    logic         fle_en = 1'b0;
    logic [1:0]   fle_out;
    logic         ccff_tail;
    logic         cfg_full;

    int n_vec = 0;
    int n_err = 0;

    // Model: chain held as a bit queue, oldest bit (the tail) at index 0.
    bit   mq[$];
    int   mcnt = 0;
    logic [1:0] mff = 2'b00;

    fle_frac_param #(.K(K), .FRAC(1)) dut (
        .clk(clk), .reset(reset), .cfg_done(cfg_done), .ccff_shift(ccff_shift),
        .ccff_head(ccff_head), .fle_in(fle_in), .fle_en(fle_en), .fle_out(fle_out),
        .ccff_tail(ccff_tail), .cfg_full(cfg_full)
    );

    always #5 clk = ~clk;

    function automatic bit cfg_bit(int j);
        return mq[W - 1 - j];
    endfunction

    function automatic logic [1:0] model_lut(logic [K-1:0] in);
        int idx;
        if (cfg_bit(N)) begin
            idx = int'(in) % (N / 2);
            return {cfg_bit(N / 2 + idx), cfg_bit(idx)};
        end
        return {1'b0, cfg_bit(int'(in))};
    endfunction

    function automatic logic [1:0] model_out();
        logic [1:0] l, o;
        l = model_lut(fle_in);
        o = 2'b00;
        if (cfg_done)
            for (int i = 0; i < 2; i++)
                o[i] = cfg_bit(N + 1 + i) ? mff[i] : l[i];
        return o;
    endfunction

    task automatic tick();
        logic [1:0] l;
        l = model_lut(fle_in);
        if (reset) mff = 2'b00;
        else if (fle_en) mff = l;
        if (reset && !cfg_done) begin
            mq.delete();
            repeat (W) mq.push_back(1'b0);
            mcnt = 0;
        end else if (ccff_shift && !cfg_done) begin
            mq.push_back(ccff_head);
            void'(mq.pop_front());
            if (mcnt < W) mcnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Shifts the packed config so the reg_sel[1] bit goes in first and LUT[0] last.
    task automatic load_cfg(input logic [N-1:0] tt, input bit frac, input logic [1:0] sel);
        logic [W-1:0] v;
        v = {sel, frac, tt};
        cfg_done = 1'b0;
        ccff_shift = 1'b1;
        for (int i = W - 1; i >= 0; i--) begin
            ccff_head = v[i];
            tick();
        end
        ccff_shift = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_done = 1'b0; ccff_shift = 1'b1; ccff_head = 1'b1; fle_en = 1'b1;
        tick();
        tick();
        reset = 1'b0; ccff_shift = 1'b0; fle_en = 1'b0;
        settle();
        n_vec++;
        if (fle_out !== 2'b00) begin n_err++; $display("[TB] FAIL reset_out got %b want 00", fle_out); end
        n_vec++;
        if (ccff_tail !== 1'b0) begin n_err++; $display("[TB] FAIL reset_tail got %b want 0", ccff_tail); end
        n_vec++;
        if (cfg_full !== 1'b0) begin n_err++; $display("[TB] FAIL reset_full got %b want 0", cfg_full); end
    endtask

    task automatic test_full_load();
        logic [W-1:0] v;
        v = {2'b00, 1'b0, 64'h8000_0000_0000_0000};
        cfg_done = 1'b0;
        ccff_shift = 1'b1;
        for (int i = W - 1; i >= 0; i--) begin
            ccff_head = v[i];
            fle_in = K'($urandom);
            tick();
            n_vec++;
            if (fle_out !== 2'b00) begin n_err++; $display("[TB] FAIL shift_quiet got %b want 00", fle_out); end
            if (i == 1) begin
                n_vec++;
                if (cfg_full !== 1'b0) begin n_err++; $display("[TB] FAIL full_early got %b want 0", cfg_full); end
            end
        end
        ccff_shift = 1'b0;
        n_vec++;
        if (cfg_full !== 1'b1) begin n_err++; $display("[TB] FAIL full_67 got %b want 1", cfg_full); end
        cfg_done = 1'b1;
        fle_in = 6'h3F;
        settle();
        n_vec++;
        if (fle_out !== 2'b01) begin n_err++; $display("[TB] FAIL load_3F got %b want 01", fle_out); end
        fle_in = 6'h3E;
        settle();
        n_vec++;
        if (fle_out !== 2'b00) begin n_err++; $display("[TB] FAIL load_3E got %b want 00", fle_out); end
    endtask

    task automatic test_fractured();
        cfg_done = 1'b0;
        settle();
        n_vec++;
        if (cfg_full !== 1'b1) begin n_err++; $display("[TB] FAIL reopen_full got %b want 1", cfg_full); end
        load_cfg({32'h0000_FFFF, 32'hFFFF_0000}, 1'b1, 2'b00);
        cfg_done = 1'b1;
        fle_in = 6'b0_10000;
        settle();
        n_vec++;
        if (fle_out !== 2'b01) begin n_err++; $display("[TB] FAIL frac_10 got %b want 01", fle_out); end
        fle_in = 6'b1_00000;
        settle();
        n_vec++;
        if (fle_out !== 2'b10) begin n_err++; $display("[TB] FAIL frac_20 got %b want 10", fle_out); end
        for (int r = 0; r < 6; r++) begin
            load_cfg({$urandom, $urandom}, r[0], 2'b00);
            cfg_done = 1'b1;
            for (int j = 0; j < 8; j++) begin
                fle_in = K'($urandom);
                settle();
                n_vec++;
                if (fle_out !== model_out()) begin
                    n_err++; $display("[TB] FAIL comb_rand got %b want %b in=%h", fle_out, model_out(), fle_in);
                end
            end
        end
    endtask

    task automatic test_registered();
        logic [1:0] held;
        load_cfg({$urandom, $urandom}, $urandom_range(0, 1), 2'b11);
        cfg_done = 1'b1;
        fle_en = 1'b1;
        for (int j = 0; j < 12; j++) begin
            fle_in = K'($urandom);
            tick();
            n_vec++;
            if (fle_out !== model_out()) begin
                n_err++; $display("[TB] FAIL reg_follow got %b want %b", fle_out, model_out());
            end
        end
        fle_en = 1'b0;
        held = mff;
        for (int j = 0; j < 5; j++) begin
            fle_in = ~fle_in;
            tick();
            n_vec++;
            if (fle_out !== held) begin n_err++; $display("[TB] FAIL reg_hold got %b want %b", fle_out, held); end
        end
    endtask

    task automatic test_reset_split();
        load_cfg(64'hF0F0_A5A5_3C3C_9669, 1'b0, 2'b11);
        cfg_done = 1'b1;
        fle_en = 1'b1;
        fle_in = 6'h00;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++;
        if (fle_out !== 2'b00) begin n_err++; $display("[TB] FAIL rst_ff got %b want 00", fle_out); end
        for (int j = 0; j < 8; j++) begin
            fle_in = K'(j * 7);
            tick();
            n_vec++;
            if (fle_out !== model_out()) begin
                n_err++; $display("[TB] FAIL rst_keep got %b want %b in=%h", fle_out, model_out(), fle_in);
            end
        end
        fle_en = 1'b0;
        cfg_done = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++;
        if (ccff_tail !== 1'b0 || cfg_full !== 1'b0) begin
            n_err++; $display("[TB] FAIL rst_chain got tail=%b full=%b want 0 0", ccff_tail, cfg_full);
        end
        ccff_shift = 1'b1;
        for (int j = 0; j < W; j++) begin
            ccff_head = 1'($urandom);
            settle();
            n_vec++;
            if (ccff_tail !== 1'b0) begin n_err++; $display("[TB] FAIL readback bit %0d got %b want 0", j, ccff_tail); end
            tick();
        end
        ccff_shift = 1'b0;
    endtask

    task automatic test_passthrough();
        bit sent[$];
        logic t0;
        logic [1:0] o0;
        cfg_done = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ccff_shift = 1'b1;
        for (int j = 0; j < 2 * W; j++) begin
            ccff_head = 1'($urandom);
            sent.push_back(ccff_head);
            tick();
            if (j >= W) begin
                n_vec++;
                if (ccff_tail !== sent[j - W + 1]) begin
                    n_err++; $display("[TB] FAIL replay bit %0d got %b want %b", j - W + 1, ccff_tail, sent[j - W + 1]);
                end
            end
        end
        cfg_done = 1'b1;
        fle_in = K'($urandom);
        settle();
        t0 = ccff_tail;
        o0 = model_out();
        for (int j = 0; j < 10; j++) begin
            ccff_head = 1'($urandom);
            tick();
            n_vec++;
            if (ccff_tail !== t0 || fle_out !== o0) begin
                n_err++; $display("[TB] FAIL lock got tail=%b out=%b want %b %b", ccff_tail, fle_out, t0, o0);
            end
        end
        ccff_shift = 1'b0;
    endtask

    task automatic test_collision();
        load_cfg({$urandom, $urandom} | 64'h1, 1'b1, 2'b10);
        cfg_done = 1'b0;
        reset = 1'b1;
        ccff_shift = 1'b1;
        ccff_head = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++;
        if (cfg_full !== 1'b0 || ccff_tail !== 1'b0) begin
            n_err++; $display("[TB] FAIL collide got full=%b tail=%b want 0 0", cfg_full, ccff_tail);
        end
        ccff_head = 1'b0;
        for (int j = 1; j <= W; j++) begin
            tick();
            n_vec++;
            if (ccff_tail !== 1'b0) begin n_err++; $display("[TB] FAIL collide_zero %0d got %b want 0", j, ccff_tail); end
            if (j == W - 1 || j == W) begin
                n_vec++;
                if (cfg_full !== (j == W)) begin
                    n_err++; $display("[TB] FAIL collide_cnt %0d got %b want %b", j, cfg_full, (j == W));
                end
            end
        end
        ccff_shift = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_fractured();
        test_registered();
        test_reset_split();
        test_passthrough();
        test_collision();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
